// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: drives hold/flush/bubble controls for load-use, taken-branch and multi-cycle Execute cases.
// Latency: 0 cycles; the controls are combinational from state and inputs, and the registers act on the next edge.
// Backpressure: pc_hold/if_id_hold stall the front end; EXE_WAIT is bounded by a timeout that sets a sticky error.
module pipeline_hazard_ctrl #(
    parameter int BR_FLUSH_CYCLES = 2,
    parameter int WAIT_TIMEOUT    = 64,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [3:0]             id_src1,
    input  logic [3:0]             id_src2,
    input  logic                   id_use_src2,
    input  logic                   ex_mem_r_en,
    input  logic [3:0]             ex_dest,
    input  logic                   ex_br_taken,
    input  logic                   ex_multi_start,
    input  logic                   ex_multi_done,
    output logic                   pc_hold,
    output logic                   if_id_hold,
    output logic                   if_id_flush,
    output logic                   id_ex_hold,
    output logic                   id_ex_bubble,
    output logic [1:0]             ctrl_state,
    output logic                   err_timeout,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int WAIT_W = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);
    localparam logic [3:0] FLUSH_INIT = 4'(BR_FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_BR_FLUSH = 2'd1,
        ST_EXE_WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [3:0]        flush_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              multi_stall;
    logic              wait_expired;

    // A load in Execute feeds a register that Decode is about to read.
    assign load_use = id_valid & ex_mem_r_en &
                      ((id_src1 == ex_dest) | (id_use_src2 & (id_src2 == ex_dest)));
    assign multi_stall  = ex_multi_start & ~ex_multi_done;
    assign wait_expired = (wait_cnt == WAIT_LAST);
    assign ctrl_state   = state;

    // Mealy control decode; everything is forced low while reset is held.
    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst) begin
            case (state)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (multi_stall) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end else if (load_use) begin
                        pc_hold      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_BR_FLUSH: begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                ST_EXE_WAIT: begin
                    if (!ex_multi_done && !wait_expired) begin
                        pc_hold    = 1'b1;
                        if_id_hold = 1'b1;
                        id_ex_hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, flush/wait counters and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_RUN;
            flush_cnt   <= 4'd0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_br_taken) begin
                        if (BR_FLUSH_CYCLES > 1) begin
                            flush_cnt <= FLUSH_INIT;
                            state     <= ST_BR_FLUSH;
                        end
                    end else if (multi_stall) begin
                        wait_cnt <= WAIT_W'(1);
                        state    <= ST_EXE_WAIT;
                    end
                end
                ST_BR_FLUSH: begin
                    flush_cnt <= flush_cnt - 4'd1;
                    if (flush_cnt == 4'd1) begin
                        state <= ST_RUN;
                    end
                end
                ST_EXE_WAIT: begin
                    if (ex_multi_done) begin
                        wait_cnt <= '0;
                        state    <= ST_RUN;
                    end else if (wait_expired) begin
                        wait_cnt    <= '0;
                        err_timeout <= 1'b1;
                        state       <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (pc_hold && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule
